// File: rtl/hh_pkg.sv
// Shared definitions for the Hodgkin-Huxley spike pipeline: sample format,
// detector state encoding and a saturating counter helper.
package hh_pkg;

    localparam int SAMPLE_W = 22;
    localparam int FRAC     = 12;
    localparam int ONE      = 4096;

    typedef enum logic [1:0] {
        ST_ARMED  = 2'd0,
        ST_ABOVE  = 2'd1,
        ST_REFRAC = 2'd2
    } hh_state_e;

    // Counters narrower than 32 bits are widened by the caller and truncated back.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/hh_spike_detector.sv
// Threshold/hysteresis spike detector with refractory window, running spike
// count and inter-spike interval, one registered cycle behind the sample.
module hh_spike_detector
    import hh_pkg::*;
#(
    parameter int W      = SAMPLE_W,
    parameter int CNT_W  = 16,
    parameter int REFRAC = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                v_valid,
    input  logic signed [W-1:0] v_in,
    input  logic signed [W-1:0] v_thresh,
    input  logic        [W-1:0] v_hyst,
    input  logic                clear,
    output logic                spike,
    output logic [CNT_W-1:0]    spike_count,
    output logic [CNT_W-1:0]    isi,
    output logic                isi_valid,
    output logic                refractory
);

    localparam int          RW      = (REFRAC > 1) ? $clog2(REFRAC + 1) : 1;
    localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

    hh_state_e              state;
    logic [CNT_W-1:0]       since_cnt;
    logic                   seen_first;
    logic [RW-1:0]          ref_cnt;

    logic signed [W+1:0]    rearm_lvl;
    logic signed [W+1:0]    v_ext;
    logic                   at_thresh;
    logic                   below_rearm;

    // Two guard bits: threshold minus a full-range unsigned hysteresis can never wrap.
    assign rearm_lvl   = $signed({{2{v_thresh[W-1]}}, v_thresh}) - $signed({2'b00, v_hyst});
    assign v_ext       = $signed({{2{v_in[W-1]}}, v_in});
    assign at_thresh   = (v_in >= v_thresh);
    assign below_rearm = (v_ext < rearm_lvl);

    assign refractory  = (state != ST_ARMED);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state       <= ST_ARMED;
            since_cnt   <= '0;
            seen_first  <= 1'b0;
            ref_cnt     <= '0;
            spike       <= 1'b0;
            spike_count <= '0;
            isi         <= '0;
            isi_valid   <= 1'b0;
        end else begin
            spike     <= 1'b0;
            isi_valid <= 1'b0;
            if (v_valid) begin
                since_cnt <= CNT_W'(sat_inc(32'(since_cnt), CNT_MAX));
                case (state)
                    ST_ARMED: begin
                        if (at_thresh) begin
                            state       <= ST_ABOVE;
                            spike       <= 1'b1;
                            spike_count <= CNT_W'(sat_inc(32'(spike_count), CNT_MAX));
                            since_cnt   <= CNT_W'(1);
                            seen_first  <= 1'b1;
                            if (seen_first) begin
                                isi       <= since_cnt;
                                isi_valid <= 1'b1;
                            end
                        end
                    end
                    ST_ABOVE: begin
                        if (below_rearm) begin
                            if (REFRAC == 0) begin
                                state <= ST_ARMED;
                            end else begin
                                state   <= ST_REFRAC;
                                ref_cnt <= RW'(REFRAC);
                            end
                        end
                    end
                    ST_REFRAC: begin
                        ref_cnt <= ref_cnt - RW'(1);
                        if (ref_cnt == RW'(1)) begin
                            state <= ST_ARMED;
                        end
                    end
                    default: state <= ST_ARMED;
                endcase
            end
        end
    end

endmodule
